// File: rtl/delay_fx_core_if.sv
// Sample-side bundle of delay_fx_core: ADC input, control settings and DAC output.
interface delay_fx_core_if #(
  parameter int DW     = 10,
  parameter int AW     = 13,
  parameter int GAIN_W = 4
);
  logic [DW-1:0]     data_in;
  logic              data_valid;
  logic [AW-1:0]     delay;
  logic [GAIN_W-1:0] gain;
  logic [1:0]        mode;
  logic [DW-1:0]     data_out;
  logic              out_valid;
  logic              busy;

  modport master (
    output data_in, data_valid, delay, gain, mode,
    input  data_out, out_valid, busy
  );

  modport slave (
    input  data_in, data_valid, delay, gain, mode,
    output data_out, out_valid, busy
  );
endinterface

// File: rtl/delay_fx_core.sv
// Four-mode audio delay effect (bypass/echo/comb/allpass) over a circular delay memory.
// Optional macro DELAY_SMOOTH_EN: read delay ramps by one sample per input toward the requested delay.
module delay_fx_core #(
  parameter int DW         = 10,
  parameter int AW         = 13,
  parameter int GAIN_W     = 4,
  parameter int ADC_OFFSET = 512,
  parameter int DAC_OFFSET = 512
) (
  input logic             sysclk_i,
  input logic             rst_i,
  delay_fx_core_if.slave  bus_if
);

  localparam int            DEPTH   = 1 << AW;
  localparam logic [DW-1:0] ADC_OFF = DW'(ADC_OFFSET);
  localparam logic [DW-1:0] DAC_OFF = DW'(DAC_OFFSET);

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_RD, S_MAC1, S_MAC2, S_OUT} state_t;

  function automatic logic signed [DW+1:0] sext2(input logic signed [DW-1:0] v);
    return {{2{v[DW-1]}}, v};
  endfunction

  function automatic logic signed [DW-1:0] sat(input logic signed [DW+1:0] v);
    if (!v[DW+1] && (v[DW:DW-1] != 2'b00)) return {1'b0, {(DW-1){1'b1}}};
    if (v[DW+1] && (v[DW:DW-1] != 2'b11))  return {1'b1, {(DW-1){1'b0}}};
    return v[DW-1:0];
  endfunction

  // (v * g) >>> GAIN_W; g < 2^GAIN_W so the result always fits back into DW bits.
  function automatic logic signed [DW-1:0] scale(input logic signed [DW-1:0] v,
                                                 input logic [GAIN_W-1:0]   g);
    logic signed [DW+GAIN_W:0] ve, ge, p;
    ve = {{(GAIN_W+1){v[DW-1]}}, v};
    ge = {{(DW+1){1'b0}}, g};
    p  = (ve * ge) >>> GAIN_W;
    return p[DW-1:0];
  endfunction

  state_t                   state_q;
  logic [AW-1:0]            wr_ptr_q, clr_cnt_q;
  logic                     dv_q, busy_q, out_valid_q;
  logic [DW-1:0]            data_out_q;
  logic [1:0]               mode_q;
  logic [GAIN_W-1:0]        gain_q;
  logic signed [DW-1:0]     x_q, mem_q, d_q, gd_q, w_q;
  logic signed [DW-1:0]     mem [DEPTH];

  logic                     edge_det, start;
  logic [AW-1:0]            delay_tgt, delay_use, rd_addr, mem_wa;
  logic                     mem_we;
  logic signed [DW-1:0]     mem_wd, gd_c, w_c, y_c;

  assign edge_det  = bus_if.data_valid & ~dv_q;
  assign start     = (state_q == S_IDLE) && edge_det;
  assign delay_tgt = (bus_if.delay == '0) ? AW'(1) : bus_if.delay;

`ifdef DELAY_SMOOTH_EN
  logic [AW-1:0] eff_delay_q, eff_delay_d;

  always_comb begin
    eff_delay_d = eff_delay_q;
    if (delay_tgt > eff_delay_q)      eff_delay_d = eff_delay_q + AW'(1);
    else if (delay_tgt < eff_delay_q) eff_delay_d = eff_delay_q - AW'(1);
  end

  always_ff @(posedge sysclk_i) begin
    if (rst_i)      eff_delay_q <= AW'(1);
    else if (start) eff_delay_q <= eff_delay_d;
  end

  assign delay_use = eff_delay_d;
`else
  assign delay_use = delay_tgt;
`endif

  assign rd_addr = wr_ptr_q - delay_use;
  assign mem_we  = (state_q == S_CLEAR) || (state_q == S_MAC2);
  assign mem_wa  = (state_q == S_CLEAR) ? clr_cnt_q : wr_ptr_q;
  assign mem_wd  = (state_q == S_CLEAR) ? '0 : w_q;

  always_ff @(posedge sysclk_i) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
    if (start)  mem_q <= mem[rd_addr];
  end

  assign gd_c = scale(d_q, gain_q);
  assign w_c  = mode_q[1] ? sat(sext2(x_q) + sext2(gd_c)) : x_q;

  always_comb begin
    y_c = x_q;
    case (mode_q)
      2'b01:   y_c = sat(sext2(x_q) + sext2(gd_q));
      2'b10:   y_c = w_q;
      2'b11:   y_c = sat(sext2(d_q) - sext2(scale(w_q, gain_q)));
      default: y_c = x_q;
    endcase
  end

  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      state_q     <= S_CLEAR;
      clr_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      dv_q        <= 1'b0;
      busy_q      <= 1'b1;
      out_valid_q <= 1'b0;
      data_out_q  <= DAC_OFF;
    end else begin
      dv_q        <= bus_if.data_valid;
      out_valid_q <= 1'b0;
      case (state_q)
        S_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + AW'(1);
          if (clr_cnt_q == {AW{1'b1}}) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_IDLE: if (edge_det) begin
          x_q     <= $signed(bus_if.data_in - ADC_OFF);
          mode_q  <= bus_if.mode;
          gain_q  <= bus_if.gain;
          busy_q  <= 1'b1;
          state_q <= S_RD;
        end
        // RD: memory word read at the edge is now valid
        S_RD: begin
          d_q     <= mem_q;
          state_q <= S_MAC1;
        end
        S_MAC1: begin
          gd_q    <= gd_c;
          w_q     <= w_c;
          state_q <= S_MAC2;
        end
        // MAC2: delay-line write happens through mem_we; output registers load here
        S_MAC2: begin
          wr_ptr_q    <= wr_ptr_q + AW'(1);
          data_out_q  <= y_c + DAC_OFF;
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  assign bus_if.data_out  = data_out_q;
  assign bus_if.out_valid = out_valid_q;
  assign bus_if.busy      = busy_q;

endmodule
